// File: rtl/serial_tx_frame_if.sv
// Handshake and serial-line bundle for serial_tx_frame.
// master: parallel producer side (drives start/data_in).
// slave:  transmitter side (drives serial_out/busy/done).
interface serial_tx_frame_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              serial_out;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data_in,
        input  serial_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output serial_out,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_tx_frame.sv
// Parametrised parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_W data bits, optional parity bit, STOP_BITS stop bits (1).
// The line idles high and every bit is held for CLKS_PER_BIT clocks.
// Optional feature: define SERIAL_TX_PARITY_EN to insert a parity bit after the data.
module serial_tx_frame #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input logic              clk,
    input logic              rst_n,
    serial_tx_frame_if.slave bus
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CW = $clog2(DATA_W + 1);

    localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BitLast  = CW'(DATA_W - 1);
    localparam logic [CW-1:0] StopLast = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SERIAL_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              baud_last;
    logic              next_bit;
    logic [DATA_W-1:0] shift_adv;

    // Bit to present next and the shift register after consuming it
    always_comb begin
        if (MSB_FIRST != 0) begin
            next_bit  = shift_q[DATA_W-1];
            shift_adv = shift_q << 1;
        end else begin
            next_bit  = shift_q[0];
            shift_adv = shift_q >> 1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: serial_d is the line value for the cycle after this edge
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        baud_last = (baud_q == BaudLast);

        unique case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (bus.start) begin
                    state_d  = StStart;
                    shift_d  = bus.data_in;
                    busy_d   = 1'b1;
                    serial_d = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = (^bus.data_in) ^ PARITY_ODD[0];
`endif
                end
            end

            StStart: begin
                if (baud_last) begin
                    state_d  = StData;
                    baud_d   = '0;
                    bit_d    = '0;
                    serial_d = next_bit;
                    shift_d  = shift_adv;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BitLast) begin
                        bit_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d  = StParity;
                        serial_d = parity_q;
`else
                        state_d  = StStop;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        serial_d = next_bit;
                        shift_d  = shift_adv;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    state_d  = StStop;
                    baud_d   = '0;
                    bit_d    = '0;
                    serial_d = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif

            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        state_d  = StIdle;
                        bit_d    = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        serial_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d  = StIdle;
                busy_d   = 1'b0;
                serial_d = 1'b1;
            end
        endcase
    end

    assign bus.serial_out = serial_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed testbench for serial_tx_frame.
// Expectations are built from frame-bit positions and hand-chosen data words;
// parity expectations follow whether SERIAL_TX_PARITY_EN is defined.
module tb_serial_tx_frame;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F0 = (1 + 8 + PAR + 1) * 4;   // default frame length
    localparam int F1 = (1 + 12 + PAR + 2) * 1;  // wide/MSB-first frame length

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_tx_frame_if #(.DATA_W(8))  if0 ();
    serial_tx_frame_if #(.DATA_W(12)) if1 ();
    serial_tx_frame_if #(.DATA_W(8))  if2 ();

    serial_tx_frame u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    serial_tx_frame #(
        .DATA_W       (12),
        .CLKS_PER_BIT (1),
        .STOP_BITS    (2),
        .MSB_FIRST    (1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    serial_tx_frame #(
        .PARITY_ODD (1)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    int checks = 0;
    int errors = 0;

    // Expected line value at offset k (k < frame length) from frame-bit positions
    function automatic logic exp_ser(input logic [31:0] d, input int w, input bit msb,
                                     input int cpb, input bit odd, input int k);
        int   b;
        logic p;
        b = k / cpb;
        p = odd;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        if (b == 0) return 1'b0;
        if (b <= w) return msb ? d[w-b] : d[b-1];
        if (PAR == 1 && b == w + 1) return p;
        return 1'b1;
    endfunction

    // Expected {serial_out, busy, done} at offset k after the accepting edge
    function automatic logic [2:0] exp_vec(input logic [31:0] d, input int w, input bit msb,
                                           input int cpb, input bit odd, input int f,
                                           input int k);
        if (k < f) return {exp_ser(d, w, msb, cpb, odd, k), 2'b10};
        if (k == f) return 3'b101;
        return 3'b100;
    endfunction

    task automatic test_reset();
        if0.start = 1'b0; if0.data_in = '0;
        if1.start = 1'b0; if1.data_in = '0;
        if2.start = 1'b0; if2.data_in = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({if0.serial_out, if0.busy, if0.done} !== 3'b100 ||
            {if1.serial_out, if1.busy, if1.done} !== 3'b100 ||
            {if2.serial_out, if2.busy, if2.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_state got %b/%b/%b exp 100",
                     {if0.serial_out, if0.busy, if0.done},
                     {if1.serial_out, if1.busy, if1.done},
                     {if2.serial_out, if2.busy, if2.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({if0.serial_out, if0.busy, if0.done} !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b exp 100", k,
                         {if0.serial_out, if0.busy, if0.done});
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] obs, exp;
        int ndone = 0;
        if0.data_in = 8'hA5; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k <= F0 + 2; k++) begin
            obs = {if0.serial_out, if0.busy, if0.done};
            exp = exp_vec(32'hA5, 8, 1'b0, 4, 1'b0, F0, k);
            if (if0.done === 1'b1) ndone++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single k=%0d got %b exp %b", k, obs, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL single_done_count got %0d exp 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs, exp;
        if0.data_in = 8'h3C; if0.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 2 * F0 + 3; k++) begin
            obs = {if0.serial_out, if0.busy, if0.done};
            if (k <= F0) exp = exp_vec(32'h3C, 8, 1'b0, 4, 1'b0, F0, k);
            else         exp = exp_vec(32'hC3, 8, 1'b0, 4, 1'b0, F0, k - F0 - 1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b exp %b", k, obs, exp);
            end
            if (k == 0) if0.data_in = 8'hC3;
            if (k == 2 * F0 + 1) if0.start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy();
        logic [2:0] obs, exp;
        int ndone = 0;
        if0.data_in = 8'h96; if0.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= F0 + 3; k++) begin
            obs = {if0.serial_out, if0.busy, if0.done};
            exp = exp_vec(32'h96, 8, 1'b0, 4, 1'b0, F0, k);
            if (if0.done === 1'b1) ndone++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ignore_busy k=%0d got %b exp %b", k, obs, exp);
            end
            if (k == 5 || k == 12 || k == 30) begin
                if0.start = 1'b1; if0.data_in = 8'hFF;
            end else begin
                if0.start = 1'b0; if0.data_in = 8'h96;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_busy_done_count got %0d exp 1", ndone);
        end
    endtask

    task automatic test_wide_msb();
        logic [2:0] obs, exp;
        if1.data_in = 12'h801; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int k = 0; k <= F1 + 2; k++) begin
            obs = {if1.serial_out, if1.busy, if1.done};
            exp = exp_vec(32'h801, 12, 1'b1, 1, 1'b0, F1, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL wide_msb k=%0d got %b exp %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    // dut0 even parity on 0x07, dut2 odd parity on 0xA5; both ignore parity when it is not built
    task automatic test_parity();
        logic [2:0] obs0, exp0, obs2, exp2;
        if0.data_in = 8'h07; if0.start = 1'b1;
        if2.data_in = 8'hA5; if2.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        if2.start = 1'b0;
        for (int k = 0; k <= F0 + 2; k++) begin
            obs0 = {if0.serial_out, if0.busy, if0.done};
            exp0 = exp_vec(32'h07, 8, 1'b0, 4, 1'b0, F0, k);
            obs2 = {if2.serial_out, if2.busy, if2.done};
            exp2 = exp_vec(32'hA5, 8, 1'b0, 4, 1'b1, F0, k);
            checks++;
            if (obs0 !== exp0) begin
                errors++;
                $display("FAIL parity_even k=%0d got %b exp %b", k, obs0, exp0);
            end
            checks++;
            if (obs2 !== exp2) begin
                errors++;
                $display("FAIL parity_odd k=%0d got %b exp %b", k, obs2, exp2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs, exp;
        int ndone = 0;
        if0.data_in = 8'h3C; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if0.serial_out, if0.busy, if0.done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_async got %b exp 100", {if0.serial_out, if0.busy, if0.done});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (if0.done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({if0.serial_out, if0.busy, if0.done} !== 3'b100 || ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_idle got %b done_pulses %0d exp 100 and 0",
                     {if0.serial_out, if0.busy, if0.done}, ndone);
        end
        if0.data_in = 8'h5A; if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        for (int k = 0; k <= F0 + 2; k++) begin
            obs = {if0.serial_out, if0.busy, if0.done};
            exp = exp_vec(32'h5A, 8, 1'b0, 4, 1'b0, F0, k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_frame k=%0d got %b exp %b", k, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_wide_msb();
        test_parity();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
